// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
//   Two-requester arbiter in front of a 4-digit multiplexed 7-segment display.
//   A granted 14-bit value is saturated to 9999, converted to BCD one bit per
//   cycle (shift-add-3), then shown on a free-running scan with leading zeros
//   blanked. Once shown, the owner may update at any time; the other requester
//   must wait until the display has been held for HOLD cycles.
//
//   Ports
//     clk, reset       : single clock, synchronous active-high reset
//     req_a/val_a      : requester A level request and binary value
//     req_b/val_b      : requester B level request and binary value
//     ack_a/ack_b      : one-cycle pulse when the matching value is latched
//     owner            : current display owner (0 = A, 1 = B)
//     busy             : high while the BCD conversion is running
//     anode            : active-low digit enables (registered)
//     cathode          : active-low segments {a..g} (registered)
module seg_display_arbiter #(
    parameter int REFRESH_BITS = 20,
    parameter int HOLD         = 100000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_a,
    input  logic [13:0] val_a,
    input  logic        req_b,
    input  logic [13:0] val_b,
    output logic        ack_a,
    output logic        ack_b,
    output logic        owner,
    output logic        busy,
    output logic [3:0]  anode,
    output logic [6:0]  cathode
);

    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HOLD_W-1:0]       HOLD_MAX = HOLD_W'(HOLD - 1);
    localparam logic [HOLD_W-1:0]       HOLD_ONE = HOLD_W'(1);
    localparam logic [REFRESH_BITS-1:0] SCAN_ONE = REFRESH_BITS'(1);

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_SHOW} state_t;

    state_t                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    last_q, last_d;      // last owner, breaks ties in IDLE
    logic                    ack_a_q, ack_a_d;
    logic                    ack_b_q, ack_b_d;
    logic [13:0]             bin_q, bin_d;        // binary shifted out MSB first
    logic [15:0]             bcd_q, bcd_d;        // BCD accumulator
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic [15:0]             digits_q, digits_d;  // displayed {thou,hund,tens,ones}
    logic                    shown_q, shown_d;    // digits_q holds a real value
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [REFRESH_BITS-1:0] scan_q, scan_d;
    logic [3:0]              anode_q, anode_d;
    logic [6:0]              cathode_q, cathode_d;

    logic        grant, grant_b;
    logic [13:0] grant_val;
    logic [15:0] bcd_adj, bcd_step;
    logic [1:0]  scan_sel;
    logic [3:0]  digit;
    logic        blank;
    logic [6:0]  seg;

    // Arbitration: IDLE favours whoever did not own last; SHOW favours the
    // owner until the hold expires, then the other requester.
    always_comb begin
        grant   = 1'b0;
        grant_b = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_a && req_b) begin
                    grant   = 1'b1;
                    grant_b = ~last_q;
                end else if (req_a || req_b) begin
                    grant   = 1'b1;
                    grant_b = req_b;
                end
            end
            S_SHOW: begin
                if ((hold_q == HOLD_MAX) && (owner_q ? req_a : req_b)) begin
                    grant   = 1'b1;
                    grant_b = ~owner_q;
                end else if (owner_q ? req_b : req_a) begin
                    grant   = 1'b1;
                    grant_b = owner_q;
                end
            end
            default: ;
        endcase
        grant_val = grant_b ? val_b : val_a;
    end

    // One shift-add-3 step: correct every nibble >= 5, then shift in next bit.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_step = {bcd_adj[14:0], bin_q[13]};
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        ack_a_d   = 1'b0;
        ack_b_d   = 1'b0;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        bit_cnt_d = bit_cnt_q;
        digits_d  = digits_q;
        shown_d   = shown_q;
        hold_d    = hold_q;
        scan_d    = scan_q + SCAN_ONE;

        if (state_q == S_SHOW) begin
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_ONE;
        end

        if (grant) begin
            state_d   = S_CONVERT;
            owner_d   = grant_b;
            last_d    = grant_b;
            ack_a_d   = ~grant_b;
            ack_b_d   = grant_b;
            bin_d     = (grant_val > 14'd9999) ? 14'd9999 : grant_val;
            bcd_d     = 16'd0;
            bit_cnt_d = 4'd0;
        end else if (state_q == S_CONVERT) begin
            bcd_d     = bcd_step;
            bin_d     = {bin_q[12:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd13) begin
                state_d  = S_SHOW;
                digits_d = bcd_step;
                shown_d  = 1'b1;
                hold_d   = '0;
            end
        end
    end

    // Scan decode with leading-zero blanking; the ones digit is never blanked.
    always_comb begin
        scan_sel = scan_q[REFRESH_BITS-1 -: 2];
        digit    = digits_q[3:0];
        blank    = 1'b0;
        anode_d  = 4'b1110;
        case (scan_sel)
            2'd0: begin
                digit   = digits_q[15:12];
                blank   = (digits_q[15:12] == 4'd0);
                anode_d = 4'b0111;
            end
            2'd1: begin
                digit   = digits_q[11:8];
                blank   = (digits_q[15:8] == 8'd0);
                anode_d = 4'b1011;
            end
            2'd2: begin
                digit   = digits_q[7:4];
                blank   = (digits_q[15:4] == 12'd0);
                anode_d = 4'b1101;
            end
            default: ;
        endcase
        if (!shown_q) blank = 1'b1;

        case (digit)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = 7'b1111111;
        endcase

        cathode_d = blank ? 7'b1111111 : seg;
        if (blank) anode_d = 4'b1111;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            bin_q     <= '0;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            digits_q  <= '0;
            shown_q   <= 1'b0;
            hold_q    <= '0;
            scan_q    <= '0;
            anode_q   <= 4'b1111;
            cathode_q <= 7'b1111111;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            ack_a_q   <= ack_a_d;
            ack_b_q   <= ack_b_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            bit_cnt_q <= bit_cnt_d;
            digits_q  <= digits_d;
            shown_q   <= shown_d;
            hold_q    <= hold_d;
            scan_q    <= scan_d;
            anode_q   <= anode_d;
            cathode_q <= cathode_d;
        end
    end

    assign ack_a   = ack_a_q;
    assign ack_b   = ack_b_q;
    assign owner   = owner_q;
    assign busy    = (state_q == S_CONVERT);
    assign anode   = anode_q;
    assign cathode = cathode_q;

endmodule
